// File: rtl/calc_perceptron_div_26s_7s_seq_pkg.sv
// Shared constants and types for the perceptron's sequential signed divider.
//   DEF_DIVIDEND_WIDTH / DEF_DIVISOR_WIDTH : default operand widths
//   LATENCY                                : enabled edges from start-accept to done
//   QMAX / QMIN                            : saturation limits of the default quotient
//   state_t                                : controller states
package calc_perceptron_div_26s_7s_seq_pkg;

  localparam int unsigned DEF_DIVIDEND_WIDTH = 26;
  localparam int unsigned DEF_DIVISOR_WIDTH  = 7;
  localparam int unsigned LATENCY            = DEF_DIVIDEND_WIDTH + 2;

  localparam logic [DEF_DIVIDEND_WIDTH-1:0] QMAX = {1'b0, {(DEF_DIVIDEND_WIDTH-1){1'b1}}};
  localparam logic [DEF_DIVIDEND_WIDTH-1:0] QMIN = {1'b1, {(DEF_DIVIDEND_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/calc_perceptron_div_step.sv
// One radix-2 restoring division iteration on magnitudes (combinational).
//   rem_in  : partial remainder (RW bits, unsigned)
//   q_in    : partial-quotient / dividend shift register (QW bits, unsigned)
//   dmag    : divisor magnitude (DW bits, unsigned)
//   rem_out : updated partial remainder
//   q_out   : shifted quotient register with the new quotient bit in the LSB
module calc_perceptron_div_step #(
  parameter int unsigned QW = 26,
  parameter int unsigned RW = 8,
  parameter int unsigned DW = 7
) (
  input  logic [RW-1:0] rem_in,
  input  logic [QW-1:0] q_in,
  input  logic [DW-1:0] dmag,
  output logic [RW-1:0] rem_out,
  output logic [QW-1:0] q_out
);

  localparam int unsigned SW = RW + 1;

  logic [SW-1:0] shifted;
  logic [SW-1:0] dext;
  logic [SW-1:0] trial;
  logic          fits;

  // Shift {rem, q} left one place, trial-subtract, restore if it went negative.
  always_comb begin
    shifted = {rem_in, q_in[QW-1]};
    dext    = SW'(dmag);
    trial   = shifted - dext;
    fits    = (shifted >= dext);
    rem_out = RW'(fits ? trial : shifted);
    q_out   = {q_in[QW-2:0], fits};
  end

endmodule

// File: rtl/calc_perceptron_div_26s_7s_seq.sv
// Sequential signed divider (26s / 7s), inverse of the perceptron weight multiplier.
// Quotient truncates toward zero, remainder takes the dividend's sign.
//   clk, reset (sync, active-low), ce (stall: holds all state)
//   start, dividend, divisor : request and operands, taken while idle
//   idle                     : ready for a new start
//   done                     : one-enabled-cycle result strobe
//   quotient, remainder      : signed results, held until the next result
//   dbz, ovf                 : divide-by-zero / saturation flags, valid with done
module calc_perceptron_div_26s_7s_seq
  import calc_perceptron_div_26s_7s_seq_pkg::*;
#(
  parameter int unsigned DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int unsigned DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      start,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      idle,
  output logic                      done,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      dbz,
  output logic                      ovf
);

  localparam int unsigned RW = DIVISOR_WIDTH + 1;
  localparam int unsigned CW = $clog2(DIVIDEND_WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(DIVIDEND_WIDTH - 1);
  localparam logic [DIVIDEND_WIDTH-1:0] Q_MAX = {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
  localparam logic [DIVIDEND_WIDTH-1:0] Q_MIN = {1'b1, {(DIVIDEND_WIDTH-1){1'b0}}};

  state_t                      state, state_n;
  logic [CW-1:0]               cnt, cnt_n;
  // Unsigned magnitude: |-2^(W-1)| = 2^(W-1) still fits in W bits.
  logic [DIVIDEND_WIDTH-1:0]   qr, qr_n;
  logic [RW-1:0]               rr, rr_n;
  logic [DIVISOR_WIDTH-1:0]    dmag, dmag_n;
  logic                        sn, sn_n, sd, sd_n;
  logic                        dbz_p, dbz_p_n, ovf_p, ovf_p_n;
  logic                        idle_n, done_n, dbz_n, ovf_n;
  logic [DIVIDEND_WIDTH-1:0]   quotient_n;
  logic [DIVISOR_WIDTH-1:0]    remainder_n;
  logic [RW-1:0]               step_r;
  logic [DIVIDEND_WIDTH-1:0]   step_q;

  calc_perceptron_div_step #(
    .QW (DIVIDEND_WIDTH),
    .RW (RW),
    .DW (DIVISOR_WIDTH)
  ) u_step (
    .rem_in  (rr),
    .q_in    (qr),
    .dmag    (dmag),
    .rem_out (step_r),
    .q_out   (step_q)
  );

  // State and datapath registers; ce freezes everything, reset overrides ce.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      qr        <= '0;
      rr        <= '0;
      dmag      <= '0;
      sn        <= 1'b0;
      sd        <= 1'b0;
      dbz_p     <= 1'b0;
      ovf_p     <= 1'b0;
      idle      <= 1'b1;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else if (ce) begin
      state     <= state_n;
      cnt       <= cnt_n;
      qr        <= qr_n;
      rr        <= rr_n;
      dmag      <= dmag_n;
      sn        <= sn_n;
      sd        <= sd_n;
      dbz_p     <= dbz_p_n;
      ovf_p     <= ovf_p_n;
      idle      <= idle_n;
      done      <= done_n;
      quotient  <= quotient_n;
      remainder <= remainder_n;
      dbz       <= dbz_n;
      ovf       <= ovf_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    qr_n        = qr;
    rr_n        = rr;
    dmag_n      = dmag;
    sn_n        = sn;
    sd_n        = sd;
    dbz_p_n     = dbz_p;
    ovf_p_n     = ovf_p;
    done_n      = 1'b0;
    quotient_n  = quotient;
    remainder_n = remainder;
    dbz_n       = dbz;
    ovf_n       = ovf;

    unique case (state)
      IDLE: begin
        if (start) begin
          qr_n    = dividend[DIVIDEND_WIDTH-1] ? -dividend : dividend;
          dmag_n  = divisor[DIVISOR_WIDTH-1] ? -divisor : divisor;
          sn_n    = dividend[DIVIDEND_WIDTH-1];
          sd_n    = divisor[DIVISOR_WIDTH-1];
          rr_n    = '0;
          cnt_n   = '0;
          dbz_p_n = (divisor == '0);
          ovf_p_n = 1'b0;
          state_n = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        qr_n  = step_q;
        rr_n  = step_r;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST_ITER) state_n = FIX;
      end
      FIX: begin
        if (dbz_p) begin
          qr_n    = sn ? Q_MIN : Q_MAX;
          rr_n    = '0;
          ovf_p_n = 1'b0;
        end else begin
          // A positive quotient with the MSB set is 2^(W-1): only -2^(W-1) / -1.
          if (!(sn ^ sd) && qr[DIVIDEND_WIDTH-1]) begin
            qr_n    = Q_MAX;
            ovf_p_n = 1'b1;
          end else begin
            qr_n    = (sn ^ sd) ? -qr : qr;
            ovf_p_n = 1'b0;
          end
          rr_n = sn ? -rr : rr;
        end
        state_n = OUT;
      end
      OUT: begin
        quotient_n  = qr;
        remainder_n = rr[DIVISOR_WIDTH-1:0];
        dbz_n       = dbz_p;
        ovf_n       = ovf_p;
        done_n      = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase

    idle_n = (state_n == IDLE);
  end

endmodule

// File: tb/tb_calc_perceptron_div_26s_7s_seq.sv
// Directed self-checking bench for calc_perceptron_div_26s_7s_seq.
// Expected values are hand-computed quotients/remainders and latencies.
module tb_calc_perceptron_div_26s_7s_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [25:0] dividend;
  logic [6:0]  divisor;
  logic        idle;
  logic        done;
  logic [25:0] quotient;
  logic [6:0]  remainder;
  logic        dbz;
  logic        ovf;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  calc_perceptron_div_26s_7s_seq dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .idle      (idle),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts edges until done is seen; returns limit on timeout.
  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (done !== 1'b1 && cycles < limit);
  endtask

  task automatic run_div(input int a, input int b, output int lat);
    dividend = 26'(a);
    divisor  = 7'(b);
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done(80, lat);
  endtask

  function automatic int qs(input logic [25:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rs(input logic [6:0] v);
    return int'($signed(v));
  endfunction

  initial begin
    int lat;
    int c;
    int pulses;

    reset    = 1'b0;
    ce       = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    chk("rst_idle", int'(idle), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_q", qs(quotient), 0);
    chk("rst_r", rs(remainder), 0);
    chk("rst_dbz", int'(dbz), 0);
    chk("rst_ovf", int'(ovf), 0);
    reset = 1'b1;
    tick();

    // 100 / 7
    run_div(100, 7, lat);
    chk("p_lat", lat, 28);
    chk("p_q", qs(quotient), 14);
    chk("p_r", rs(remainder), 2);
    chk("p_dbz", int'(dbz), 0);
    chk("p_ovf", int'(ovf), 0);
    chk("p_idle_at_done", int'(idle), 1);
    tick();
    chk("p_done_one_cycle", int'(done), 0);
    chk("p_hold_q", qs(quotient), 14);

    // sign combinations
    run_div(-100, 7, lat);
    chk("nd_q", qs(quotient), -14);
    chk("nd_r", rs(remainder), -2);
    run_div(100, -7, lat);
    chk("nv_q", qs(quotient), -14);
    chk("nv_r", rs(remainder), 2);
    run_div(-100, -7, lat);
    chk("nn_q", qs(quotient), 14);
    chk("nn_r", rs(remainder), -2);
    chk("nn_lat", lat, 28);

    // overflow corner
    run_div(-33554432, -1, lat);
    chk("ovf_q", qs(quotient), 33554431);
    chk("ovf_r", rs(remainder), 0);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_dbz", int'(dbz), 0);

    // -2^25 / 1 fits exactly
    run_div(-33554432, 1, lat);
    chk("min_q", qs(quotient), -33554432);
    chk("min_ovf", int'(ovf), 0);

    // divide by zero
    run_div(5, 0, lat);
    chk("dbz_lat", lat, 2);
    chk("dbz_q", qs(quotient), 33554431);
    chk("dbz_r", rs(remainder), 0);
    chk("dbz_flag", int'(dbz), 1);
    chk("dbz_ovf", int'(ovf), 0);
    run_div(-5, 0, lat);
    chk("dbzn_q", qs(quotient), -33554432);
    chk("dbzn_flag", int'(dbz), 1);

    // ce stall mid-CALC plus an ignored start while busy
    dividend = 26'(100);
    divisor  = 7'(7);
    start    = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    tick(); c++;
    tick(); c++;
    chk("busy_idle", int'(idle), 0);
    dividend = 26'(50);
    divisor  = 7'(5);
    start    = 1'b1;
    tick(); c++;
    start = 1'b0;
    ce    = 1'b0;
    repeat (10) begin tick(); c++; end
    ce = 1'b1;
    wait_done(80, lat);
    chk("stall_lat", c + lat, 38);
    chk("stall_q", qs(quotient), 14);
    chk("stall_r", rs(remainder), 2);
    // done holds while ce is low
    ce = 1'b0;
    tick();
    tick();
    chk("done_hold_ce0", int'(done), 1);
    ce = 1'b1;
    tick();
    chk("done_drop_ce1", int'(done), 0);
    pulses = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("no_extra_done", pulses, 0);

    // reset mid-division
    dividend = 26'(1000);
    divisor  = 7'(3);
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mrst_idle", int'(idle), 1);
    chk("mrst_done", int'(done), 0);
    chk("mrst_q", qs(quotient), 0);
    chk("mrst_r", rs(remainder), 0);
    pulses = 0;
    repeat (35) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    chk("mrst_no_done", pulses, 0);
    run_div(63, -64, lat);
    chk("m64_q", qs(quotient), 0);
    chk("m64_r", rs(remainder), 63);

    // back-to-back with start held high
    dividend = 26'(1000);
    divisor  = 7'(3);
    start    = 1'b1;
    tick();
    dividend = 26'(999);
    divisor  = 7'(-9);
    wait_done(80, lat);
    chk("b2b1_lat", lat, 28);
    chk("b2b1_q", qs(quotient), 333);
    chk("b2b1_r", rs(remainder), 1);
    tick();
    start = 1'b0;
    wait_done(80, lat);
    chk("b2b_gap", lat + 1, 29);
    chk("b2b2_q", qs(quotient), -111);
    chk("b2b2_r", rs(remainder), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
